// File: rtl/gate_response_checker.sv
// gate_response_checker - sweeps the four {a,b} vectors into a 2-input gate
// and checks each settled response against a programmable truth table.
module gate_response_checker #(
  parameter logic [3:0] TRUTH  = 4'b1000,
  parameter int         SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       a,
  output logic       b,
  input  logic       y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_cnt,
  output logic       fail_valid,
  output logic [1:0] first_fail
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  state_t     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] err_cnt_q, err_cnt_d;
  logic       fail_valid_q, fail_valid_d;
  logic [1:0] first_fail_q, first_fail_d;
  logic       pass_q, pass_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      idx_q        <= 2'd0;
      cnt_q        <= 4'd0;
      err_cnt_q    <= 3'd0;
      fail_valid_q <= 1'b0;
      first_fail_q <= 2'd0;
      pass_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      err_cnt_q    <= err_cnt_d;
      fail_valid_q <= fail_valid_d;
      first_fail_q <= first_fail_d;
      pass_q       <= pass_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    err_cnt_d    = err_cnt_q;
    fail_valid_d = fail_valid_q;
    first_fail_d = first_fail_q;
    pass_d       = pass_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d      = S_SETTLE;
          idx_d        = 2'd0;
          cnt_d        = 4'd0;
          err_cnt_d    = 3'd0;
          fail_valid_d = 1'b0;
          first_fail_d = 2'd0;
          pass_d       = 1'b0;
        end
      end
      S_SETTLE: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == SETTLE_LAST) begin
          state_d = S_SAMPLE;
        end
      end
      S_SAMPLE: begin
        if (y != TRUTH[idx_q]) begin
          err_cnt_d = err_cnt_q + 3'd1;
          if (!fail_valid_q) begin
            first_fail_d = idx_q;
            fail_valid_d = 1'b1;
          end
        end
        if (idx_q == 2'd3) begin
          state_d = S_DONE;
          // Resolved here so pass is already valid during the done cycle.
          pass_d  = (err_cnt_d == 3'd0);
        end else begin
          idx_d   = idx_q + 2'd1;
          cnt_d   = 4'd0;
          state_d = S_SETTLE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy       = (state_q == S_SETTLE) || (state_q == S_SAMPLE);
  assign done       = (state_q == S_DONE);
  assign a          = busy & idx_q[1];
  assign b          = busy & idx_q[0];
  assign pass       = pass_q;
  assign err_cnt    = err_cnt_q;
  assign fail_valid = fail_valid_q;
  assign first_fail = first_fail_q;

endmodule

// File: tb/tb_gate_response_checker.sv
// tb_gate_response_checker - directed checks of the gate sweep harness.
module tb_gate_response_checker;

  logic       clk;
  logic       rst;
  logic       start;
  logic       a, b, y, busy, done, pass, fail_valid;
  logic [2:0] err_cnt;
  logic [1:0] first_fail;
  logic       start1;
  logic       a1, b1, y1, busy1, done1, pass1, fail_valid1;
  logic [2:0] err_cnt1;
  logic [1:0] first_fail1;
  int         mode;
  int         errors;
  int         checks;

  gate_response_checker #(.TRUTH(4'b1000), .SETTLE(2)) u0 (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .y(y),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
    .fail_valid(fail_valid), .first_fail(first_fail)
  );

  gate_response_checker #(.TRUTH(4'b1000), .SETTLE(1)) u1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .y(y1),
    .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err_cnt1),
    .fail_valid(fail_valid1), .first_fail(first_fail1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // mode 0: AND gate, 1: OR gate, 2: y tied high
  always_comb begin
    y = a & b;
    case (mode)
      1: y = a | b;
      2: y = 1'b1;
      default: y = a & b;
    endcase
  end
  assign y1 = a1 & b1;

  task automatic test_reset();
    if ({a, b, busy, done, pass, err_cnt, fail_valid, first_fail} !== 10'd0) begin
      errors++;
      $display("FAIL reset_u0 got=%b exp=%b",
               {a, b, busy, done, pass, err_cnt, fail_valid, first_fail}, 10'd0);
    end
    checks++;
    if ({a1, b1, busy1, done1, pass1, err_cnt1, fail_valid1, first_fail1} !== 10'd0) begin
      errors++;
      $display("FAIL reset_u1 got=%b exp=%b",
               {a1, b1, busy1, done1, pass1, err_cnt1, fail_valid1, first_fail1}, 10'd0);
    end
    checks++;
  endtask

  task automatic test_and_sweep();
    logic [3:0] exp_io;
    int n;
    mode = 0;
    @(negedge clk) start = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      start = (c == 5);  // pulse while busy must be ignored
      n = (c - 1) / 3;
      if (c <= 12)      exp_io = {n[1], n[0], 1'b1, 1'b0};
      else if (c == 13) exp_io = 4'b0001;
      else              exp_io = 4'b0000;
      if ({a, b, busy, done} !== exp_io) begin
        errors++;
        $display("FAIL and_io cycle=%0d got=%b exp=%b", c, {a, b, busy, done}, exp_io);
      end
      checks++;
      if (c == 13 || c == 16) begin
        if ({pass, err_cnt, fail_valid, first_fail} !== 7'b1_000_0_00) begin
          errors++;
          $display("FAIL and_result cycle=%0d got=%b exp=%b", c,
                   {pass, err_cnt, fail_valid, first_fail}, 7'b1_000_0_00);
        end
        checks++;
      end
    end
  endtask

  task automatic test_or_mismatch();
    mode = 1;
    @(negedge clk) start = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 13) begin
        if ({done, pass, err_cnt, fail_valid, first_fail} !== 8'b1_0_010_1_01) begin
          errors++;
          $display("FAIL or_result got=%b exp=%b",
                   {done, pass, err_cnt, fail_valid, first_fail}, 8'b1_0_010_1_01);
        end
        checks++;
      end
    end
  endtask

  task automatic test_tie1_then_and();
    mode = 2;
    @(negedge clk) start = 1'b1;
    for (int c = 1; c <= 28; c++) begin
      @(negedge clk);
      start = (c == 14);
      if (c == 14) mode = 0;
      if (c == 13) begin
        if ({done, pass, err_cnt, fail_valid, first_fail} !== 8'b1_0_011_1_00) begin
          errors++;
          $display("FAIL tie1_result got=%b exp=%b",
                   {done, pass, err_cnt, fail_valid, first_fail}, 8'b1_0_011_1_00);
        end
        checks++;
      end
      if (c == 15) begin
        if ({busy, pass, err_cnt, fail_valid, first_fail} !== 8'b1_0_000_0_00) begin
          errors++;
          $display("FAIL tie1_clear_on_start got=%b exp=%b",
                   {busy, pass, err_cnt, fail_valid, first_fail}, 8'b1_0_000_0_00);
        end
        checks++;
      end
      if (c == 27) begin
        if ({done, pass, err_cnt, fail_valid} !== 6'b1_1_000_0) begin
          errors++;
          $display("FAIL rerun_and_result got=%b exp=%b",
                   {done, pass, err_cnt, fail_valid}, 6'b1_1_000_0);
        end
        checks++;
      end
    end
  endtask

  task automatic test_reset_midsweep();
    int done_seen;
    mode = 2;
    done_seen = 0;
    @(negedge clk) start = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      start = (c == 15);
      if (c == 6) begin
        if (err_cnt !== 3'd1 || busy !== 1'b1) begin
          errors++;
          $display("FAIL midsweep_pre_reset got=%0d/%b exp=1/1", err_cnt, busy);
        end
        checks++;
        rst = 1'b1;
      end
      if (c == 7) begin
        rst  = 1'b0;
        mode = 0;
        if ({a, b, busy, done, pass, err_cnt, fail_valid, first_fail} !== 10'd0) begin
          errors++;
          $display("FAIL midsweep_reset got=%b exp=%b",
                   {a, b, busy, done, pass, err_cnt, fail_valid, first_fail}, 10'd0);
        end
        checks++;
      end
      if (c >= 8 && c <= 15 && done) done_seen++;
      if (c == 28) begin
        if ({done, pass, err_cnt} !== 5'b1_1_000) begin
          errors++;
          $display("FAIL after_reset_sweep got=%b exp=%b", {done, pass, err_cnt}, 5'b1_1_000);
        end
        checks++;
      end
    end
    if (done_seen != 0) begin
      errors++;
      $display("FAIL midsweep_no_done got=%0d exp=0", done_seen);
    end
    checks++;
  endtask

  task automatic test_back_to_back();
    logic exp_done, exp_busy;
    @(negedge clk) start1 = 1'b1;
    for (int c = 1; c <= 35; c++) begin
      @(negedge clk);
      if (c == 30) start1 = 1'b0;
      exp_done = (c == 9) || (c == 19) || (c == 29);
      exp_busy = !((c == 9) || (c == 10) || (c == 19) || (c == 20) || (c >= 29));
      if ({busy1, done1} !== {exp_busy, exp_done}) begin
        errors++;
        $display("FAIL b2b cycle=%0d got busy,done=%b exp=%b", c, {busy1, done1},
                 {exp_busy, exp_done});
      end
      checks++;
      if (c == 9 && pass1 !== 1'b1) begin
        errors++;
        $display("FAIL b2b_pass got=%b exp=1", pass1);
      end
      if (c == 9) checks++;
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b1;
    start  = 1'b0;
    start1 = 1'b0;
    mode   = 0;
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b0;
    @(negedge clk);
    test_and_sweep();
    test_or_mismatch();
    test_tie1_then_and();
    test_reset_midsweep();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gate_response_checker.md
# gate_response_checker

Synthesizable self-checking harness for a 2-input combinational gate. It generates the four input vectors for the gate, samples the gate's response after a settle interval, and compares each response against a programmable truth table. It reports the error count, the first failing vector, and pass/fail through a start/done handshake. It sits beside a gate instance (e.g. the AND gate) on the FPGA and replaces the simulation-only stimulus bench with an on-chip, repeatable check.

## Interface
- TRUTH, 4'b1000, expected y per vector; bit index = {a,b} (4'b1000 = AND, 4'b1110 = OR)
- SETTLE, 2, cycles each vector is driven before y is sampled; legal range 1..15
- clk  input  1  rising-edge clock
- rst  input  1  reset, synchronous, active-high
- start  input  1  request a sweep; accepted only in IDLE
- a  output  1  gate input A (vector MSB)
- b  output  1  gate input B (vector LSB)
- y  input  1  gate output under test
- busy  output  1  high while a sweep is in progress (SETTLE/SAMPLE)
- done  output  1  one-cycle pulse at sweep end
- pass  output  1  1 when the last completed sweep had zero mismatches; held until next accepted start
- err_cnt  output  3  mismatch count of current/last sweep (0..4)
- fail_valid  output  1  at least one mismatch in current/last sweep
- first_fail  output  2  vector index {a,b} of the first mismatch; valid when fail_valid=1

## Operation
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE: a=b=0, busy=0. start=1 -> SETTLE, idx<=0, settle counter<=0, err_cnt<=0, fail_valid<=0, first_fail<=0, pass<=0.
- SETTLE: {a,b}=idx; counter increments each cycle; when counter==SETTLE-1 -> SAMPLE.
- SAMPLE: {a,b} still = idx; compare y with TRUTH[idx]. On mismatch: err_cnt+1. If fail_valid=0, first_fail<=idx and fail_valid<=1. Then idx==3 -> DONE; else idx+1, counter<=0 -> SETTLE.
- DONE: done=1 for this cycle only, a=b=0, busy=0, pass<=(err_cnt==0) including a mismatch from the final SAMPLE. Unconditionally -> IDLE.
- Vector order is fixed: 00, 01, 10, 11.
- start is ignored in SETTLE, SAMPLE, and DONE; it is not queued.
- err_cnt never exceeds 4 (3 bits suffice, no wrap).
- y is sampled only in SAMPLE; y changes at any other time have no effect.

## Timing
- Reset values: state=IDLE, a=0, b=0, busy=0, done=0, pass=0, err_cnt=0, fail_valid=0, first_fail=0.
- rst has priority over all inputs. Reset mid-sweep aborts it: all outputs return to reset values on the next edge and no done pulse is produced.
- Start is sampled in cycle 0. Vector n is driven during cycles 1+n·(SETTLE+1) through (n+1)·(SETTLE+1), and y is sampled in the last cycle of that window.
- done is high in cycle 4·(SETTLE+1)+1. With SETTLE=2 this is cycle 13; with SETTLE=1 it is cycle 9.
- Results (pass, err_cnt, fail_valid, first_fail) are stable from the done cycle until the next accepted start.
- If start is held high continuously, sweeps run back-to-back with one IDLE cycle between done and the next acceptance.

## Test plan
- AND gate attached, TRUTH=4'b1000, SETTLE=2, pulse start -> a,b step 00,01,10,11 every 3 cycles; done in cycle 13; pass=1, err_cnt=0, fail_valid=0.
- OR gate attached, TRUTH=4'b1000 -> mismatches at 01 and 10; err_cnt=2, fail_valid=1, first_fail=2'b01, pass=0.
- y tied to 1, TRUTH=4'b1000 -> err_cnt=3, first_fail=2'b00, pass=0; then AND attached and start pulsed again -> results clear at acceptance, final pass=1.
- rst asserted in cycle 6 of a sweep -> next cycle all outputs at reset values, no done pulse; a following start completes normally with done in cycle 13.
- SETTLE=1, start held high for 30 cycles -> done in cycles 9 and 19 (IDLE in cycles 10 and 20), busy low only in DONE/IDLE cycles; start pulses while busy produce no extra sweep.
